// File: rtl/modn_pkg.sv
// -----------------------------------------------------------------------------
// modn_pkg
// Shared definitions for the serial divisibility checker:
//   - state_t  : per-channel frame state (IDLE = 0, ACTIVE = 1)
//   - clog2()  : ceiling log2 with a floor of 1, used to size remainder buses
// -----------------------------------------------------------------------------
package modn_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Width needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage : modn_pkg

// File: rtl/modn_channel.sv
// -----------------------------------------------------------------------------
// modn_channel
// One serial channel: receives a frame MSB first and reports the frame value
// modulo MOD, whether it is divisible by MOD, and the (saturating) bit count.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   start     : first bit of a frame is on data this cycle
//   stop      : last bit of a frame is on data this cycle
//   data      : serial data bit
//   done      : one-cycle pulse, the cycle after stop, when a result is shown
//   result    : 1 when the last completed frame is divisible by MOD
//   remainder : last completed frame value mod MOD (held until next done)
//   length    : last completed frame bit count, saturating at 2^LEN_W-1
//   err       : one-cycle pulse after an aborted frame or a stray stop
// -----------------------------------------------------------------------------
module modn_channel
  import modn_pkg::*;
#(
  parameter int  MOD   = 3,
  parameter int  LEN_W = 8,
  localparam int REM_W = clog2(MOD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             data,
  output logic             done,
  output logic             result,
  output logic [REM_W-1:0] remainder,
  output logic [LEN_W-1:0] length,
  output logic             err
);

  localparam logic [REM_W:0]   MOD_EXT = (REM_W + 1)'(MOD);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t r_state;
  state_t w_state_next;

  logic [REM_W-1:0] r_rem;
  logic [LEN_W-1:0] r_len;

  logic             r_done;
  logic             r_err;
  logic             r_result;
  logic [REM_W-1:0] r_remainder;
  logic [LEN_W-1:0] r_length;

  logic [REM_W:0]   w_rem_dbl;
  logic [REM_W:0]   w_rem_sub;
  logic [REM_W-1:0] w_rem_step;
  logic [REM_W-1:0] w_rem_first;
  logic [REM_W-1:0] w_rem_new;
  logic [LEN_W-1:0] w_len_step;
  logic [LEN_W-1:0] w_len_new;

  logic w_load;      // start of a frame: reload rem/len from this bit
  logic w_step;      // continuing frame: shift this bit in
  logic w_finish;    // this bit closes the frame: publish next cycle
  logic w_err_next;  // framing violation seen this cycle

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // A start together with stop is a complete 1-bit frame, so it never leaves
  // IDLE; any stop in ACTIVE ends the frame, even when it restarts it.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_state_next = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (stop) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / action decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_load     = start;
    w_step     = 1'b0;
    w_finish   = 1'b0;
    w_err_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_finish   = start & stop;
        w_err_next = stop & ~start;
      end
      ST_ACTIVE: begin
        w_step     = ~start;
        w_finish   = stop;
        w_err_next = start;   // restart aborts the frame in flight
      end
      default: begin
        w_step = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Remainder / length datapath
  // 2*rem+data is at most 2*MOD-1, so one conditional subtraction of MOD
  // brings it back into 0..MOD-1 without a divider.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rem_dbl   = {r_rem, data};
    w_rem_sub   = w_rem_dbl - MOD_EXT;
    w_rem_step  = REM_W'((w_rem_dbl >= MOD_EXT) ? w_rem_sub : w_rem_dbl);
    // A single bit is already below the divisor, which is at least 2.
    w_rem_first    = '0;
    w_rem_first[0] = data;
    w_len_step  = (r_len == LEN_MAX) ? r_len : r_len + LEN_ONE;
    w_rem_new   = w_load ? w_rem_first : w_rem_step;
    w_len_new   = w_load ? LEN_ONE : w_len_step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem       <= '0;
      r_len       <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_result    <= 1'b0;
      r_remainder <= '0;
      r_length    <= '0;
    end else begin
      if (w_load || w_step) begin
        r_rem <= w_rem_new;
        r_len <= w_len_new;
      end
      r_done <= w_finish;
      r_err  <= w_err_next;
      // Published values only move on a completed frame.
      if (w_finish) begin
        r_remainder <= w_rem_new;
        r_length    <= w_len_new;
        r_result    <= (w_rem_new == '0);
      end
    end
  end

  assign done      = r_done;
  assign err       = r_err;
  assign result    = r_result;
  assign remainder = r_remainder;
  assign length    = r_length;

endmodule : modn_channel

// File: rtl/modn_checker.sv
// -----------------------------------------------------------------------------
// modn_checker
// CHANNELS independent serial divisibility checkers sharing one clock/reset.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   start     : [CHANNELS]         per-channel frame start
//   stop      : [CHANNELS]         per-channel frame end
//   data      : [CHANNELS]         per-channel serial bit, MSB first
//   done      : [CHANNELS]         per-channel result-valid pulse
//   result    : [CHANNELS]         per-channel divisible flag
//   remainder : [CHANNELS*REM_W]   channel i at [i*REM_W +: REM_W]
//   length    : [CHANNELS*LEN_W]   channel i at [i*LEN_W +: LEN_W]
//   err       : [CHANNELS]         per-channel framing-error pulse
// -----------------------------------------------------------------------------
module modn_checker
  import modn_pkg::*;
#(
  parameter int  MOD      = 3,
  parameter int  CHANNELS = 1,
  parameter int  LEN_W    = 8,
  localparam int REM_W    = clog2(MOD)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS-1:0]       data,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       result,
  output logic [CHANNELS*REM_W-1:0] remainder,
  output logic [CHANNELS*LEN_W-1:0] length,
  output logic [CHANNELS-1:0]       err
);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      modn_channel #(
        .MOD   (MOD),
        .LEN_W (LEN_W)
      ) u_ch (
        .clk       (clk),
        .rst       (rst),
        .start     (start[gi]),
        .stop      (stop[gi]),
        .data      (data[gi]),
        .done      (done[gi]),
        .result    (result[gi]),
        .remainder (remainder[gi*REM_W +: REM_W]),
        .length    (length[gi*LEN_W +: LEN_W]),
        .err       (err[gi])
      );
    end
  endgenerate

endmodule : modn_checker

// File: doc/modn_checker.md
MODN_CHECKER -- requirements
Module: modn_checker

Interface
REQ-001 SHALL have parameter MOD, default 3: divisor, legal range 2..255.
REQ-002 SHALL have parameter CHANNELS, default 1: independent serial channels, legal range 1..16.
REQ-003 SHALL have parameter LEN_W, default 8: width of the frame-length counter.
REQ-004 SHALL have local parameter REM_W = clog2(MOD), minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port start, input, CHANNELS bits: per-channel frame start; the data bit in the same cycle is the first bit of the frame.
REQ-008 SHALL have port stop, input, CHANNELS bits: per-channel frame end; the data bit in the same cycle is the last bit of the frame.
REQ-009 SHALL have port data, input, CHANNELS bits: per-channel serial bit, MSB first.
REQ-010 SHALL have port done, output, CHANNELS bits: one-cycle pulse when a frame result is presented.
REQ-011 SHALL have port result, output, CHANNELS bits: 1 when the frame value is divisible by MOD; valid while done is 1.
REQ-012 SHALL have port remainder, output, CHANNELS*REM_W bits: frame value mod MOD; channel i occupies bits [i*REM_W +: REM_W].
REQ-013 SHALL have port length, output, CHANNELS*LEN_W bits: number of bits in the frame, saturating; channel i occupies [i*LEN_W +: LEN_W].
REQ-014 SHALL have port err, output, CHANNELS bits: one-cycle pulse on a framing violation.

Function
REQ-015 SHALL give each channel the states IDLE and ACTIVE; every channel SHALL be fully independent of the others.
REQ-016 SHALL, in IDLE, move to ACTIVE on start=1 and stop=0, loading rem=(0*2+data) mod MOD and len=1.
REQ-017 SHALL, in ACTIVE with start=0, update rem=(2*rem+data) mod MOD and len=min(len+1, 2^LEN_W-1) every cycle.
REQ-018 SHALL compute the remainder update in REM_W+1 bits with a single conditional subtraction of MOD, with no divider.
REQ-019 SHALL, on stop=1 (in ACTIVE, or together with start in any state), include that cycle's data bit and return to IDLE.
REQ-020 SHALL, in the cycle after that stop, pulse done=1 and present remainder = final rem, result = (final rem == 0) and length = final len.
REQ-021 SHALL hold remainder, result and length stable after the done pulse until the next done.
REQ-022 SHALL treat start and stop together in one cycle as a 1-bit frame: done follows next cycle with rem=data mod MOD and len=1.
REQ-023 SHALL, on start=1 in ACTIVE, abort the current frame, pulse err in the next cycle, and restart the frame with that cycle's bit; no done is produced for the aborted frame.
REQ-024 SHALL, on stop=1 in IDLE without start, pulse err in the next cycle and otherwise ignore the stop; no done is produced.
REQ-025 SHALL ignore data in IDLE when start=0.
REQ-026 SHALL have a latency of exactly 1 cycle from the stop edge to done.
REQ-027 SHALL accept back-to-back frames, i.e. start in the cycle after stop, without any lost bit.

Reset
REQ-028 SHALL, on rst=1, immediately and asynchronously force all channels to IDLE, internal rem and len to 0, done/err/result to 0, and remainder/length to 0.
REQ-029 SHALL, on rst during ACTIVE, discard the frame with no done and no err pulse.
REQ-030 SHALL make the first frame accepted after reset deassertion one whose start is sampled on a clock edge with rst=0.

Structure
REQ-031 SHALL place the state encoding (IDLE=0, ACTIVE=1) and the clog2 helper function in the shared package modn_pkg.
REQ-032 SHALL implement one sub-module, modn_channel (a single channel FSM plus datapath), instantiated CHANNELS times by a generate loop.
REQ-033 SHALL make the top level contain only the generate loop and bus slicing.

Verification
REQ-034 SHALL cover: MOD=3, frame bits 1,1,0 (value 6) -> done in the cycle after stop, result=1, remainder=0, length=3.
REQ-035 SHALL cover: MOD=5, frame bits 1,1,0,1 (value 13) -> result=0, remainder=3, length=4.
REQ-036 SHALL cover: MOD=7, start and stop together with data=1 -> next cycle done=1, remainder=1, length=1, result=0.
REQ-037 SHALL cover: MOD=3, start, bits 1,0, then start again with bits 1,1 and stop -> err pulse after the second start, a single done with remainder=0 and length=2.
REQ-038 SHALL cover: CHANNELS=2, ch0 value 9 and ch1 value 10 with overlapping frames at MOD=3 -> ch0 result=1, ch1 remainder=1, with no cross-talk between channels.
REQ-039 SHALL cover: LEN_W=3, a 10-bit frame -> length saturates at 7 and the remainder is still correct; plus rst mid-frame -> no done and all outputs 0.
